latch_id_ex: RTL

LATCH_ID_EX -- requirements
Module: latch_id_ex

---
 rtl/latch_id_ex_pkg.sv | 26 ++
 rtl/latch_id_ex.sv | 130 +++++++++++++
 2 files changed

// File: rtl/latch_id_ex_pkg.sv
// ---------------------------------------------------------------------------
// latch_id_ex_pkg
// Shared definitions for the ID/EX pipeline latch.
// Contents:
//   - bit positions of each field inside the packed control word
//     {reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst, alu_op[3:0]}
//   - default control-word width
//   - width and saturation value of the bubble counter
// ---------------------------------------------------------------------------
package latch_id_ex_pkg;

    localparam int CTRL_WIDTH      = 10;

    localparam int CTRL_REG_WRITE  = 9;
    localparam int CTRL_MEM_TO_REG = 8;
    localparam int CTRL_MEM_READ   = 7;
    localparam int CTRL_MEM_WRITE  = 6;
    localparam int CTRL_ALU_SRC    = 5;
    localparam int CTRL_REG_DST    = 4;
    localparam int CTRL_ALU_OP_MSB = 3;
    localparam int CTRL_ALU_OP_LSB = 0;

    localparam int                BUBBLE_COUNT_WIDTH = 16;
    localparam logic [15:0]       BUBBLE_COUNT_MAX   = 16'hFFFF;

endpackage

// File: rtl/latch_id_ex.sv
// ---------------------------------------------------------------------------
// latch_id_ex
// ID/EX pipeline register with inline load-use hazard detection and bubble
// insertion.
// Ports:
//   i_clock               rising-edge clock
//   i_soft_reset          asynchronous active-low reset (loads a bubble)
//   i_enable              pipeline advance; low freezes every register
//   i_flush               branch/jump taken in ID, next capture is a bubble
//   i_rs_id/i_rt_id/i_rd_id        register fields decoded in ID
//   i_dato_rs_id/i_dato_rt_id      register-file read data
//   i_inmediato_id                 sign-extended immediate
//   i_control_id                   packed control word
//   o_rs_ex/o_rt_ex                registered sources (forwarding unit)
//   o_registro_destino_ex          registered destination (rd or rt)
//   o_dato_rs_ex/o_dato_rt_ex/o_inmediato_ex  registered operands
//   o_control_ex                   registered control word
//   o_stall               combinational load-use hazard
//   o_cant_burbujas       saturating count of inserted bubbles
// ---------------------------------------------------------------------------
module latch_id_ex
    import latch_id_ex_pkg::*;
#(
    parameter int CANT_BITS_ADDR_REGISTROS = 5,
    parameter int CANT_BITS_REGISTROS      = 32,
    parameter int CANT_BITS_CONTROL        = CTRL_WIDTH
)(
    input  logic                                i_clock,
    input  logic                                i_soft_reset,
    input  logic                                i_enable,
    input  logic                                i_flush,
    input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_rs_id,
    input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_rt_id,
    input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_rd_id,
    input  logic [CANT_BITS_REGISTROS-1:0]      i_dato_rs_id,
    input  logic [CANT_BITS_REGISTROS-1:0]      i_dato_rt_id,
    input  logic [CANT_BITS_REGISTROS-1:0]      i_inmediato_id,
    input  logic [CANT_BITS_CONTROL-1:0]        i_control_id,
    output logic [CANT_BITS_ADDR_REGISTROS-1:0] o_rs_ex,
    output logic [CANT_BITS_ADDR_REGISTROS-1:0] o_rt_ex,
    output logic [CANT_BITS_ADDR_REGISTROS-1:0] o_registro_destino_ex,
    output logic [CANT_BITS_REGISTROS-1:0]      o_dato_rs_ex,
    output logic [CANT_BITS_REGISTROS-1:0]      o_dato_rt_ex,
    output logic [CANT_BITS_REGISTROS-1:0]      o_inmediato_ex,
    output logic [CANT_BITS_CONTROL-1:0]        o_control_ex,
    output logic                                o_stall,
    output logic [BUBBLE_COUNT_WIDTH-1:0]       o_cant_burbujas
);

    logic [CANT_BITS_ADDR_REGISTROS-1:0] r_rs_ex;
    logic [CANT_BITS_ADDR_REGISTROS-1:0] r_rt_ex;
    logic [CANT_BITS_ADDR_REGISTROS-1:0] r_registro_destino_ex;
    logic [CANT_BITS_REGISTROS-1:0]      r_dato_rs_ex;
    logic [CANT_BITS_REGISTROS-1:0]      r_dato_rt_ex;
    logic [CANT_BITS_REGISTROS-1:0]      r_inmediato_ex;
    logic [CANT_BITS_CONTROL-1:0]        r_control_ex;
    logic [BUBBLE_COUNT_WIDTH-1:0]       r_cant_burbujas;

    logic                                w_stall;
    logic                                w_bubble;
    logic [CANT_BITS_ADDR_REGISTROS-1:0] w_destino;
    logic [CANT_BITS_CONTROL-1:0]        w_control_captura;

    // Load-use hazard: the instruction now in EX is a load whose target
    // register is read by the instruction in ID. Register 0 never creates a
    // hazard because it is hardwired. This does not look at i_enable so the
    // debug unit always sees the true hazard state.
    assign w_stall = r_control_ex[CTRL_MEM_READ]
                   && (r_rt_ex != '0)
                   && ((r_rt_ex == i_rs_id) || (r_rt_ex == i_rt_id));

    // A flush and a stall on the same edge still produce a single bubble.
    assign w_bubble = i_flush || w_stall;

    // Destination selection and reg_write suppression for register 0, so the
    // forwarding unit never treats register 0 as a producer.
    always_comb begin
        w_destino         = i_control_id[CTRL_REG_DST] ? i_rd_id : i_rt_id;
        w_control_captura = i_control_id;
        if (w_destino == '0) begin
            w_control_captura[CTRL_REG_WRITE] = 1'b0;
        end
    end

    // Pipeline register. Reset and bubbles zero the control word and the
    // register addresses; operand data is passed through even on a bubble
    // since nothing downstream uses it once the control word is zero. The
    // bubble counter stops at its maximum instead of wrapping.
    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            r_rs_ex               <= '0;
            r_rt_ex               <= '0;
            r_registro_destino_ex <= '0;
            r_dato_rs_ex          <= '0;
            r_dato_rt_ex          <= '0;
            r_inmediato_ex        <= '0;
            r_control_ex          <= '0;
            r_cant_burbujas       <= '0;
        end else if (i_enable) begin
            r_dato_rs_ex   <= i_dato_rs_id;
            r_dato_rt_ex   <= i_dato_rt_id;
            r_inmediato_ex <= i_inmediato_id;
            if (w_bubble) begin
                r_rs_ex               <= '0;
                r_rt_ex               <= '0;
                r_registro_destino_ex <= '0;
                r_control_ex          <= '0;
                if (r_cant_burbujas != BUBBLE_COUNT_MAX) begin
                    r_cant_burbujas <= r_cant_burbujas + 16'd1;
                end
            end else begin
                r_rs_ex               <= i_rs_id;
                r_rt_ex               <= i_rt_id;
                r_registro_destino_ex <= w_destino;
                r_control_ex          <= w_control_captura;
            end
        end
    end

    assign o_rs_ex               = r_rs_ex;
    assign o_rt_ex               = r_rt_ex;
    assign o_registro_destino_ex = r_registro_destino_ex;
    assign o_dato_rs_ex          = r_dato_rs_ex;
    assign o_dato_rt_ex          = r_dato_rt_ex;
    assign o_inmediato_ex        = r_inmediato_ex;
    assign o_control_ex          = r_control_ex;
    assign o_stall               = w_stall;
    assign o_cant_burbujas       = r_cant_burbujas;

endmodule
